wf_exec_mask_table: RTL and testbench
=====================================

Name: wf_exec_mask_table

Overview:
- Per-wavefront storage of the 64-bit EXEC mask for all 40 wavefront slots.
- Publishes every entry on one flattened 2560-bit bus, which feeds the downstream 40:1 64-bit selector that picks the issuing wavefront's mask by wfid.
- Written by the dispatcher at wavefront launch and by the SALU on EXEC writes; cleared at wavefront retire.
- Tracks a per-wavefront SALU-write-pending scoreboard so issue can stall vector instructions until EXEC is final.

Parameters:
NUM_WF, 40, number of wavefront slots
MASK_W, 64, EXEC mask width (lo half = bits 31:0, hi half = bits 63:32)
WFID_W, 6, wavefront id width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dispatch_en  in  1  launch wavefront dispatch_wfid
dispatch_wfid  in  6  slot being launched
dispatch_mask  in  64  initial EXEC
salu_issue_en  in  1  SALU instruction writing EXEC issued for salu_issue_wfid
salu_issue_wfid  in  6  wavefront of issued EXEC-writer
salu_wr_en  in  1  SALU EXEC write-back
salu_wr_wfid  in  6  target wavefront
salu_wr_lo_en  in  1  write bits 31:0
salu_wr_hi_en  in  1  write bits 63:32
salu_wr_data  in  64  write data
retire_en  in  1  wavefront retire
retire_wfid  in  6  slot retiring
exec_flat  out  2560  entry i at bits [64*i+63:64*i]
exec_valid  out  40  slot i holds a live wavefront
exec_pending  out  40  slot i has an outstanding SALU EXEC write
err_illegal  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: all mask entries = 0; exec_valid, exec_pending, err_illegal = 0. Reset overrides every request in the same cycle.
- All outputs are registered. An update presented in cycle N is visible on outputs in cycle N+1. There is no combinational path from inputs to outputs.
- Dispatch (wfid < 40):
  - mask[wfid] <= dispatch_mask, valid <= 1, pending <= 0.
  - Dispatch to a slot already valid: still performed; err_illegal pulses.
- SALU issue: valid slot only; pending[wfid] <= 1.
- SALU write: valid slot only.
  - lo_en updates bits 31:0; hi_en updates bits 63:32. Halves not enabled keep their value.
  - pending[wfid] <= 0 when either enable is set.
  - lo_en = hi_en = 0 with salu_wr_en = 1: no-op, no error.
- Retire: valid slot; mask <= 0, valid <= 0, pending <= 0.
- Requests to a slot with valid = 0 (SALU issue, SALU write, retire) are ignored and raise err_illegal.
- Any wfid >= 40 on an enabled port: request ignored, err_illegal pulses.
- Same-cycle events, different slots: all applied independently.
- Same-cycle events, same slot, priority highest first: retire > dispatch > SALU write > SALU issue.
  - Lower-priority requests to that slot are dropped.
  - err_illegal pulses, except for SALU write + SALU issue on the same slot.
- SALU write + SALU issue on the same valid slot, same cycle: data written, pending ends at 1. The new writer is outstanding.
- err_illegal is the OR of all error conditions in cycle N, registered, so it is high for cycle N+1 only.
- Reset mid-operation: pending and valid are cleared. Outstanding SALU writes arriving after reset hit invalid slots and are flagged.

Decomposition:
- Shared package holds NUM_WF, MASK_W, WFID_W, and the flattened-bus slice helper (offset = 64*wfid). The downstream selector uses the same package.
- One sub-module: wf_exec_mask_entry. It holds one slot: 64-bit register, valid and pending bits, half-write enables, and the local priority resolve.
- Instantiate it 40 times with decoded per-slot strobes. The top level does wfid decode, range checks and error aggregation.

Test Plan:
- Reset, then dispatch wfid 5, mask 64'hFFFF_FFFF_FFFF_FFFF -> next cycle exec_flat[383:320] = all ones, exec_valid[5] = 1, other slots 0.
- Dispatch wfid 39, mask 64'h0000_0000_DEAD_BEEF; then salu_issue wfid 39 -> exec_pending[39] = 1. Then salu_wr lo_en only, data 64'h1234_5678_0000_000F -> exec_flat[2559:2496] = 64'h0000_0000_0000_000F, pending[39] = 0.
- salu_wr to never-dispatched wfid 7 -> mask 7 stays 0, err_illegal high exactly one cycle.
- Same cycle: retire wfid 3 and salu_wr wfid 3, data 64'h1 -> entry 3 = 0, valid[3] = 0, err_illegal pulses.
- Same cycle: salu_wr and salu_issue to valid wfid 10, both halves, data 64'hA5A5_A5A5_5A5A_5A5A -> entry = that data, pending[10] = 1, err_illegal = 0.
- dispatch_wfid = 40 -> no state change, err_illegal pulses. Then assert rst with pending bits set -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/wf_exec_mask_table_pkg.sv
// Shared sizing and bus-layout helpers for the wavefront EXEC mask table
// and the downstream per-wavefront mask selector.
package wf_exec_mask_table_pkg;

  localparam int NUM_WF = 40;
  localparam int MASK_W = 64;
  localparam int WFID_W = 6;
  localparam int HALF_W = MASK_W / 2;
  localparam int FLAT_W = NUM_WF * MASK_W;

  // Bit offset of a wavefront's mask inside the flattened bus.
  function automatic int unsigned flat_offset(input int unsigned wfid);
    return wfid * MASK_W;
  endfunction

endpackage

// File: rtl/wf_exec_mask_entry.sv
// One wavefront slot: EXEC mask, live bit and SALU-write-pending bit, with
// local priority resolve (retire > dispatch > SALU write > SALU issue).
module wf_exec_mask_entry
  import wf_exec_mask_table_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_i,
  input  logic [MASK_W-1:0] dispatch_mask_i,
  input  logic              issue_i,
  input  logic              wr_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [MASK_W-1:0] wr_data_i,
  input  logic              retire_i,
  output logic [MASK_W-1:0] mask_o,
  output logic              valid_o,
  output logic              pending_o,
  output logic              err_o
);

  logic [MASK_W-1:0] mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              pending_q, pending_d;

  always_comb begin
    mask_d    = mask_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    err_o     = 1'b0;
    if (retire_i) begin
      if (valid_q) begin
        mask_d    = '0;
        valid_d   = 1'b0;
        pending_d = 1'b0;
      end else begin
        err_o = 1'b1;
      end
      if (dispatch_i || wr_i || issue_i) err_o = 1'b1;
    end else if (dispatch_i) begin
      mask_d    = dispatch_mask_i;
      valid_d   = 1'b1;
      pending_d = 1'b0;
      if (valid_q || wr_i || issue_i) err_o = 1'b1;
    end else if (wr_i) begin
      if (valid_q) begin
        if (wr_lo_i) mask_d[HALF_W-1:0]      = wr_data_i[HALF_W-1:0];
        if (wr_hi_i) mask_d[MASK_W-1:HALF_W] = wr_data_i[MASK_W-1:HALF_W];
        if (wr_lo_i || wr_hi_i) pending_d = 1'b0;
        // A writer issued in the same cycle is still outstanding.
        if (issue_i) pending_d = 1'b1;
      end else begin
        err_o = 1'b1;
      end
    end else if (issue_i) begin
      if (valid_q) pending_d = 1'b1;
      else         err_o     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  assign mask_o    = mask_q;
  assign valid_o   = valid_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/wf_exec_mask_table.sv
// Per-wavefront EXEC mask table: decodes wfids to per-slot strobes, range
// checks each request port and aggregates errors into a registered pulse.
module wf_exec_mask_table
  import wf_exec_mask_table_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_en,
  input  logic [WFID_W-1:0] dispatch_wfid,
  input  logic [MASK_W-1:0] dispatch_mask,
  input  logic              salu_issue_en,
  input  logic [WFID_W-1:0] salu_issue_wfid,
  input  logic              salu_wr_en,
  input  logic [WFID_W-1:0] salu_wr_wfid,
  input  logic              salu_wr_lo_en,
  input  logic              salu_wr_hi_en,
  input  logic [MASK_W-1:0] salu_wr_data,
  input  logic              retire_en,
  input  logic [WFID_W-1:0] retire_wfid,
  output logic [FLAT_W-1:0] exec_flat,
  output logic [NUM_WF-1:0] exec_valid,
  output logic [NUM_WF-1:0] exec_pending,
  output logic              err_illegal
);

  logic [MASK_W-1:0] entry_mask [NUM_WF];
  logic [NUM_WF-1:0] slot_err;
  logic              range_err;
  logic              err_q;

  // Out-of-range wfids decode to no slot, so they only need flagging here.
  assign range_err = (dispatch_en   && (dispatch_wfid   >= WFID_W'(NUM_WF))) ||
                     (salu_issue_en && (salu_issue_wfid >= WFID_W'(NUM_WF))) ||
                     (salu_wr_en    && (salu_wr_wfid    >= WFID_W'(NUM_WF))) ||
                     (retire_en     && (retire_wfid     >= WFID_W'(NUM_WF)));

  for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
    wf_exec_mask_entry u_entry (
      .clk             (clk),
      .rst             (rst),
      .dispatch_i      (dispatch_en   && (dispatch_wfid   == WFID_W'(i))),
      .dispatch_mask_i (dispatch_mask),
      .issue_i         (salu_issue_en && (salu_issue_wfid == WFID_W'(i))),
      .wr_i            (salu_wr_en    && (salu_wr_wfid    == WFID_W'(i))),
      .wr_lo_i         (salu_wr_lo_en),
      .wr_hi_i         (salu_wr_hi_en),
      .wr_data_i       (salu_wr_data),
      .retire_i        (retire_en     && (retire_wfid     == WFID_W'(i))),
      .mask_o          (entry_mask[i]),
      .valid_o         (exec_valid[i]),
      .pending_o       (exec_pending[i]),
      .err_o           (slot_err[i])
    );
  end

  always_comb begin
    exec_flat = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      exec_flat[flat_offset(i) +: MASK_W] = entry_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (|slot_err) || range_err;
  end

  assign err_illegal = err_q;

endmodule

// File: tb/tb_wf_exec_mask_table.sv
// Directed table-driven bench for wf_exec_mask_table with an expected-result queue.
module tb_wf_exec_mask_table;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_en;
  logic [5:0]    dispatch_wfid;
  logic [63:0]   dispatch_mask;
  logic          salu_issue_en;
  logic [5:0]    salu_issue_wfid;
  logic          salu_wr_en;
  logic [5:0]    salu_wr_wfid;
  logic          salu_wr_lo_en;
  logic          salu_wr_hi_en;
  logic [63:0]   salu_wr_data;
  logic          retire_en;
  logic [5:0]    retire_wfid;
  logic [2559:0] exec_flat;
  logic [39:0]   exec_valid;
  logic [39:0]   exec_pending;
  logic          err_illegal;

  wf_exec_mask_table dut (
    .clk(clk), .rst(rst),
    .dispatch_en(dispatch_en), .dispatch_wfid(dispatch_wfid), .dispatch_mask(dispatch_mask),
    .salu_issue_en(salu_issue_en), .salu_issue_wfid(salu_issue_wfid),
    .salu_wr_en(salu_wr_en), .salu_wr_wfid(salu_wr_wfid),
    .salu_wr_lo_en(salu_wr_lo_en), .salu_wr_hi_en(salu_wr_hi_en), .salu_wr_data(salu_wr_data),
    .retire_en(retire_en), .retire_wfid(retire_wfid),
    .exec_flat(exec_flat), .exec_valid(exec_valid), .exec_pending(exec_pending),
    .err_illegal(err_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  wf;
    logic [63:0] mask;
    logic [39:0] valid;
    logic [39:0] pend;
    logic        err;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    logic        d_en;  logic [5:0] d_wf; logic [63:0] d_mask;
    logic        i_en;  logic [5:0] i_wf;
    logic        w_en;  logic [5:0] w_wf; logic w_lo; logic w_hi; logic [63:0] w_data;
    logic        r_en;  logic [5:0] r_wf;
    exp_t        e;
  } vec_t;

  logic [EXP_W-1:0] exp_q[$];
  vec_t             tbl[$];
  int               checks = 0;
  int               failures = 0;

  function automatic logic [39:0] bv(input int a);
    logic [39:0] one;
    one = 40'd1;
    return one << a;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.d_en = 0; v.d_wf = 0; v.d_mask = 0;
    v.i_en = 0; v.i_wf = 0;
    v.w_en = 0; v.w_wf = 0; v.w_lo = 0; v.w_hi = 0; v.w_data = 0;
    v.r_en = 0; v.r_wf = 0;
    v.e = '0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t v, input int wf, input logic [63:0] mask,
                                    input logic [39:0] valid, input logic [39:0] pend,
                                    input logic err);
    vec_t r;
    r = v;
    r.e.wf = 6'(wf); r.e.mask = mask; r.e.valid = valid; r.e.pend = pend; r.e.err = err;
    return r;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    dispatch_en = v.d_en; dispatch_wfid = v.d_wf; dispatch_mask = v.d_mask;
    salu_issue_en = v.i_en; salu_issue_wfid = v.i_wf;
    salu_wr_en = v.w_en; salu_wr_wfid = v.w_wf; salu_wr_lo_en = v.w_lo;
    salu_wr_hi_en = v.w_hi; salu_wr_data = v.w_data;
    retire_en = v.r_en; retire_wfid = v.r_wf;
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // scoreboard: pop one expectation and compare it to what the DUT shows now
  task automatic score(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty vec=%0d actual=0 expected=1", idx);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("mask",  idx, exec_flat[64*int'(e.wf) +: 64], e.mask);
      check("valid", idx, 64'(exec_valid), 64'(e.valid));
      check("pend",  idx, 64'(exec_pending), 64'(e.pend));
      check("err",   idx, 64'(err_illegal), 64'(e.err));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    exp_q.push_back(EXP_W'(v.e));
    @(posedge clk); #1;
    score(idx);
  endtask

  initial begin
    vec_t v;
    logic [39:0] vl;

    rst = 1'b1;
    drive(idle());
    repeat (3) @(posedge clk);
    #1;
    check("rst_flat", -1, 64'(|exec_flat), 64'd0);
    check("rst_valid", -1, 64'(exec_valid), 64'd0);
    check("rst_pend", -1, 64'(exec_pending), 64'd0);
    check("rst_err", -1, 64'(err_illegal), 64'd0);
    rst = 1'b0;

    // 0: dispatch 5 all ones
    v = idle(); v.d_en = 1; v.d_wf = 5; v.d_mask = '1;
    tbl.push_back(with_exp(v, 5, '1, bv(5), 0, 0));
    // 1: dispatch 39
    vl = bv(5) | bv(39);
    v = idle(); v.d_en = 1; v.d_wf = 39; v.d_mask = 64'h0000_0000_DEAD_BEEF;
    tbl.push_back(with_exp(v, 39, 64'h0000_0000_DEAD_BEEF, vl, 0, 0));
    // 2: issue 39
    v = idle(); v.i_en = 1; v.i_wf = 39;
    tbl.push_back(with_exp(v, 39, 64'h0000_0000_DEAD_BEEF, vl, bv(39), 0));
    // 3: lo-only write to 39
    v = idle(); v.w_en = 1; v.w_wf = 39; v.w_lo = 1; v.w_data = 64'h1234_5678_0000_000F;
    tbl.push_back(with_exp(v, 39, 64'h0000_0000_0000_000F, vl, 0, 0));
    // 4: write to never-dispatched 7, then 5: error drops
    v = idle(); v.w_en = 1; v.w_wf = 7; v.w_lo = 1; v.w_hi = 1; v.w_data = '1;
    tbl.push_back(with_exp(v, 7, 0, vl, 0, 1));
    tbl.push_back(with_exp(idle(), 7, 0, vl, 0, 0));
    // 6: dispatch 3, 7: retire 3 + write 3
    v = idle(); v.d_en = 1; v.d_wf = 3; v.d_mask = 64'h3333;
    tbl.push_back(with_exp(v, 3, 64'h3333, vl | bv(3), 0, 0));
    v = idle(); v.r_en = 1; v.r_wf = 3; v.w_en = 1; v.w_wf = 3; v.w_lo = 1; v.w_hi = 1;
    v.w_data = 64'h1;
    tbl.push_back(with_exp(v, 3, 0, vl, 0, 1));
    // 8: dispatch 10
    vl = bv(5) | bv(10) | bv(39);
    v = idle(); v.d_en = 1; v.d_wf = 10; v.d_mask = 0;
    tbl.push_back(with_exp(v, 10, 0, vl, 0, 0));
    // 9: write + issue same valid slot
    v = idle(); v.w_en = 1; v.w_wf = 10; v.w_lo = 1; v.w_hi = 1;
    v.w_data = 64'hA5A5_A5A5_5A5A_5A5A; v.i_en = 1; v.i_wf = 10;
    tbl.push_back(with_exp(v, 10, 64'hA5A5_A5A5_5A5A_5A5A, vl, bv(10), 0));
    // 10: write with no half enabled: no-op
    v = idle(); v.w_en = 1; v.w_wf = 10; v.w_data = '1;
    tbl.push_back(with_exp(v, 10, 64'hA5A5_A5A5_5A5A_5A5A, vl, bv(10), 0));
    // 11: hi-only write
    v = idle(); v.w_en = 1; v.w_wf = 10; v.w_hi = 1; v.w_data = 64'hFFFF_FFFF_0000_0000;
    tbl.push_back(with_exp(v, 10, 64'hFFFF_FFFF_5A5A_5A5A, vl, 0, 0));
    // 12: dispatch out of range
    v = idle(); v.d_en = 1; v.d_wf = 40; v.d_mask = '1;
    tbl.push_back(with_exp(v, 10, 64'hFFFF_FFFF_5A5A_5A5A, vl, 0, 1));
    // 13: re-dispatch live slot 5
    v = idle(); v.d_en = 1; v.d_wf = 5; v.d_mask = 64'h55;
    tbl.push_back(with_exp(v, 5, 64'h55, vl, 0, 1));
    // 14: independent events on three slots
    vl = vl | bv(20);
    v = idle(); v.d_en = 1; v.d_wf = 20; v.d_mask = 64'h20; v.i_en = 1; v.i_wf = 5;
    v.w_en = 1; v.w_wf = 39; v.w_hi = 1; v.w_data = 64'hABCD_0000_0000_0000;
    tbl.push_back(with_exp(v, 20, 64'h20, vl, bv(5), 0));
    // 15: retire 39 (check merged write from previous cycle first via new vector)
    v = idle();
    tbl.push_back(with_exp(v, 39, 64'hABCD_0000_0000_000F, vl, bv(5), 0));
    vl = bv(5) | bv(10) | bv(20);
    v = idle(); v.r_en = 1; v.r_wf = 39;
    tbl.push_back(with_exp(v, 39, 0, vl, bv(5), 0));
    // 17: retire 39 again: illegal
    tbl.push_back(with_exp(v, 39, 0, vl, bv(5), 1));
    // 18: issue 10, 19: dispatch 10 + write 10, 20: issue 10
    v = idle(); v.i_en = 1; v.i_wf = 10;
    tbl.push_back(with_exp(v, 10, 64'hFFFF_FFFF_5A5A_5A5A, vl, bv(5) | bv(10), 0));
    v = idle(); v.d_en = 1; v.d_wf = 10; v.d_mask = 64'h77;
    v.w_en = 1; v.w_wf = 10; v.w_lo = 1; v.w_hi = 1; v.w_data = '1;
    tbl.push_back(with_exp(v, 10, 64'h77, vl, bv(5), 1));
    v = idle(); v.i_en = 1; v.i_wf = 10;
    tbl.push_back(with_exp(v, 10, 64'h77, vl, bv(5) | bv(10), 0));
    // 21: issue to out-of-range wfid
    v = idle(); v.i_en = 1; v.i_wf = 63;
    tbl.push_back(with_exp(v, 10, 64'h77, vl, bv(5) | bv(10), 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset with pending bits set, overriding a same-cycle dispatch
    v = idle(); v.d_en = 1; v.d_wf = 1; v.d_mask = '1;
    drive(v);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_flat", 100, 64'(|exec_flat), 64'd0);
    check("rst2_valid", 100, 64'(exec_valid), 64'd0);
    check("rst2_pend", 100, 64'(exec_pending), 64'd0);
    check("rst2_err", 100, 64'(err_illegal), 64'd0);

    // late SALU write after reset hits an invalid slot
    v = idle(); v.w_en = 1; v.w_wf = 5; v.w_lo = 1; v.w_hi = 1; v.w_data = '1;
    apply(with_exp(v, 5, 0, 0, 0, 1), 101);
    apply(with_exp(idle(), 5, 0, 0, 0, 0), 102);

    check("sb_drained", 103, 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
